// File: rtl/cv32e40p_tmr_fault_injector_if.sv
// Control, status and replica buses of the TMR fault injector.
// slave: injector side; master: campaign controller / TMR wrapper side.
interface cv32e40p_tmr_fault_injector_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             arm_i;
  logic             abort_i;
  logic [1:0]       target_i;
  logic [1:0]       mode_i;
  logic [WIDTH-1:0] mask_i;
  logic [CNT_W-1:0] delay_i;
  logic [CNT_W-1:0] len_i;
  logic             trig_i;
  logic [WIDTH-1:0] res0_i;
  logic [WIDTH-1:0] res1_i;
  logic [WIDTH-1:0] res2_i;
  logic [WIDTH-1:0] res0_o;
  logic [WIDTH-1:0] res1_o;
  logic [WIDTH-1:0] res2_o;
  logic             busy_o;
  logic             inject_o;
  logic             done_o;
  logic [CNT_W-1:0] inj_count_o;

  modport slave (
    input  arm_i, abort_i, target_i, mode_i,
    input  mask_i, delay_i, len_i, trig_i,
    input  res0_i, res1_i, res2_i,
    output res0_o, res1_o, res2_o,
    output busy_o, inject_o, done_o, inj_count_o
  );

  modport master (
    output arm_i, abort_i, target_i, mode_i,
    output mask_i, delay_i, len_i, trig_i,
    output res0_i, res1_i, res2_i,
    input  res0_o, res1_o, res2_o,
    input  busy_o, inject_o, done_o, inj_count_o
  );
endinterface

// File: rtl/cv32e40p_tmr_fault_injector.sv
// Corrupts one TMR replica result for a programmed window ahead of the voters.
// Ports: clk, rst_n (async low), bus (slave: config in, replicas in/out, status out).
module cv32e40p_tmr_fault_injector #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  cv32e40p_tmr_fault_injector_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_INJECT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       tgt_q, tgt_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] inj_q, inj_d;
  logic             done_q, done_d;

  logic             inj_act;
  logic [CNT_W-1:0] len_eff;

  // Single-bit flip always lasts one cycle; a zero length means one.
  assign len_eff = (bus.mode_i == 2'b00 || bus.len_i == '0)
                 ? CNT_W'(1) : bus.len_i;

  assign inj_act = (state_q == S_INJECT) && (tgt_q != 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      mode_q  <= '0;
      mask_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      inj_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      inj_q   <= inj_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.arm_i) begin
          tgt_d  = bus.target_i;
          mode_d = bus.mode_i;
          mask_d = bus.mask_i;
          len_d  = len_eff;
          if (bus.delay_i == '0) begin
            state_d = S_INJECT;
            cnt_d   = len_eff;
          end else begin
            state_d = S_DELAY;
            cnt_d   = bus.delay_i;
          end
        end
      end
      S_DELAY: begin
        if (bus.trig_i) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_INJECT;
            cnt_d   = len_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_INJECT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort outranks arm and completion; config latched above is harmless.
    if (bus.abort_i) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      tgt_d   = tgt_q;
      mode_d  = mode_q;
      mask_d  = mask_q;
      len_d   = len_q;
    end
  end

  // The cycle being aborted was still corrupted, so it is counted.
  always_comb begin
    inj_d = inj_q;
    if (inj_act && inj_q != '1) inj_d = inj_q + CNT_W'(1);
  end

  function automatic logic [WIDTH-1:0] corrupt(
    input logic [WIDTH-1:0] r
  );
    logic [WIDTH-1:0] f;
    unique case (1'b1)
      !mode_q[1]:         f = r ^ mask_q;
      mode_q == 2'b10:    f = r | mask_q;
      default:            f = r & ~mask_q;
    endcase
    return f;
  endfunction

  always_comb begin
    bus.res0_o = bus.res0_i;
    bus.res1_o = bus.res1_i;
    bus.res2_o = bus.res2_i;
    if (inj_act && tgt_q == 2'd0) bus.res0_o = corrupt(bus.res0_i);
    if (inj_act && tgt_q == 2'd1) bus.res1_o = corrupt(bus.res1_i);
    if (inj_act && tgt_q == 2'd2) bus.res2_o = corrupt(bus.res2_i);
    bus.busy_o      = (state_q != S_IDLE);
    bus.inject_o    = inj_act;
    bus.done_o      = done_q;
    bus.inj_count_o = inj_q;
  end

endmodule

// File: tb/tb_cv32e40p_tmr_fault_injector.sv
// Self-checking bench for cv32e40p_tmr_fault_injector.
// Directed campaigns plus randomized traffic against a campaign-level model.
module tb_cv32e40p_tmr_fault_injector;
  localparam int W   = 32;
  localparam int CW  = 16;
  localparam int SCW = 4;
  localparam int VW  = 3 * W + 3 + CW;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_n_s;
  always #5 clk = ~clk;

  cv32e40p_tmr_fault_injector_if #(.WIDTH(W), .CNT_W(CW))  bif ();
  cv32e40p_tmr_fault_injector_if #(.WIDTH(W), .CNT_W(SCW)) sif ();

  cv32e40p_tmr_fault_injector #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  cv32e40p_tmr_fault_injector #(.WIDTH(W), .CNT_W(SCW)) u_sat (
    .clk   (clk),
    .rst_n (rst_n_s),
    .bus   (sif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Campaign model: remaining qualified delay cycles and remaining
  // corrupted cycles; injecting whenever active with no delay left.
  bit          m_act;
  int          m_dleft;
  int          m_lleft;
  int          m_tgt;
  int          m_mode;
  logic [W-1:0] m_mask;
  bit          m_done;
  logic [CW-1:0] m_cnt;

  function automatic bit m_inj_win();
    return m_act && m_dleft == 0;
  endfunction

  function automatic bit m_inj();
    return m_inj_win() && m_tgt != 3;
  endfunction

  function automatic logic [W-1:0] m_res(int k, logic [W-1:0] r);
    if (!(m_inj_win() && m_tgt == k)) return r;
    case (m_mode)
      0, 1:    return r ^ m_mask;
      2:       return r | m_mask;
      default: return r & ~m_mask;
    endcase
  endfunction

  function automatic logic [VW-1:0] m_vec();
    return {m_res(0, bif.res0_i), m_res(1, bif.res1_i),
            m_res(2, bif.res2_i), m_act, m_inj(), m_done, m_cnt};
  endfunction

  function automatic logic [VW-1:0] d_vec();
    return {bif.res0_o, bif.res1_o, bif.res2_o,
            bif.busy_o, bif.inject_o, bif.done_o, bif.inj_count_o};
  endfunction

  task automatic m_clear();
    m_act = 0; m_dleft = 0; m_lleft = 0; m_tgt = 0;
    m_mode = 0; m_mask = '0; m_done = 0; m_cnt = '0;
  endtask

  // Advance one clock and the model with the inputs seen at that edge.
  task automatic tick();
    bit arm, ab, tr;
    int tgt, mode, dly, len;
    logic [W-1:0] mask;
    arm = bif.arm_i; ab = bif.abort_i; tr = bif.trig_i;
    tgt = int'(bif.target_i); mode = int'(bif.mode_i);
    dly = int'(bif.delay_i); len = int'(bif.len_i);
    mask = bif.mask_i;
    @(posedge clk);
    m_done = 0;
    if (m_inj() && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    if (ab) begin
      m_act = 0;
    end else if (!m_act) begin
      if (arm) begin
        m_act = 1; m_tgt = tgt; m_mode = mode; m_mask = mask;
        m_dleft = dly;
        m_lleft = (mode == 0 || len == 0) ? 1 : len;
      end
    end else if (m_dleft > 0) begin
      if (tr) m_dleft--;
    end else begin
      m_lleft--;
      if (m_lleft == 0) begin
        m_act = 0; m_done = 1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bif.arm_i = 0; bif.abort_i = 0; bif.target_i = 0; bif.mode_i = 0;
    bif.mask_i = '0; bif.delay_i = '0; bif.len_i = '0; bif.trig_i = 1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] g, e;
    rst_n = 0; rst_n_s = 0;
    idle_inputs();
    bif.res0_i = 32'h1234_5678; bif.res1_i = 32'h1234_5678;
    bif.res2_i = 32'h1234_5678;
    sif.arm_i = 0; sif.abort_i = 0; sif.target_i = 0; sif.mode_i = 0;
    sif.mask_i = '0; sif.delay_i = '0; sif.len_i = '0; sif.trig_i = 1;
    sif.res0_i = 32'h1234_5678; sif.res1_i = 32'h1234_5678;
    sif.res2_i = 32'h1234_5678;
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1; rst_n_s = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      g = d_vec();
      e = {{3{32'h1234_5678}}, 3'b000, {CW{1'b0}}};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL reset cyc%0d got %h exp %h", i, g, e);
      end
      tick();
    end
  endtask

  task automatic test_single();
    logic [VW-1:0] g, e;
    idle_inputs();
    bif.arm_i = 1; bif.target_i = 1; bif.mode_i = 0;
    bif.mask_i = 32'h0000_0001; bif.delay_i = 0; bif.len_i = 7;
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (bif.res1_o !== 32'h1234_5679 || bif.inject_o !== 1'b1) begin
      n_bad++;
      $display("FAIL single res1 got %h/%b exp 12345679/1",
               bif.res1_o, bif.inject_o);
    end
    for (int i = 0; i < 3; i++) begin
      g = d_vec(); e = m_vec();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL single cyc%0d got %h exp %h", i, g, e);
      end
      tick();
      #1;
    end
    n_cmp++;
    if (bif.inj_count_o !== 16'd1) begin
      n_bad++;
      $display("FAIL single count got %0d exp 1", bif.inj_count_o);
    end
  endtask

  task automatic test_stuck_trig();
    logic [VW-1:0] g, e;
    logic [CW-1:0] c0;
    int hits;
    hits = 0;
    c0 = bif.inj_count_o;
    idle_inputs();
    bif.arm_i = 1; bif.target_i = 2; bif.mode_i = 2;
    bif.mask_i = 32'hFF00_0000; bif.delay_i = 3; bif.len_i = 4;
    bif.trig_i = 0;
    tick();
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      bif.trig_i = i[0];
      #1;
      if (bif.res2_o === 32'hFF34_5678) hits++;
      g = d_vec(); e = m_vec();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL stuck cyc%0d got %h exp %h", i, g, e);
      end
      tick();
    end
    n_cmp++;
    if (hits != 4 || bif.inj_count_o !== c0 + 16'd4) begin
      n_bad++;
      $display("FAIL stuck window got %0d/%0d exp 4/%0d",
               hits, bif.inj_count_o, c0 + 16'd4);
    end
    bif.trig_i = 1;
  endtask

  task automatic test_abort();
    logic [VW-1:0] g, e;
    logic [CW-1:0] c0;
    c0 = bif.inj_count_o;
    idle_inputs();
    bif.arm_i = 1; bif.abort_i = 1; bif.target_i = 0; bif.delay_i = 0;
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (bif.busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL arm+abort busy got %b exp 0", bif.busy_o);
    end
    bif.arm_i = 1; bif.target_i = 0; bif.mode_i = 1;
    bif.mask_i = 32'h0F0F_0F0F; bif.delay_i = 0; bif.len_i = 8;
    tick();
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin
        bif.arm_i = 1; bif.target_i = 2; bif.mode_i = 3;
        bif.mask_i = '1; bif.len_i = 1;
      end
      if (i == 2) bif.abort_i = 1;
      #1;
      g = d_vec(); e = m_vec();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL abort cyc%0d got %h exp %h", i, g, e);
      end
      tick();
      idle_inputs();
    end
    n_cmp++;
    if (bif.inj_count_o !== c0 + 16'd3 || bif.res0_o !== bif.res0_i) begin
      n_bad++;
      $display("FAIL abort count got %0d exp %0d",
               bif.inj_count_o, c0 + 16'd3);
    end
  endtask

  task automatic test_dry_run();
    logic [VW-1:0] g, e;
    logic [CW-1:0] c0;
    int nbusy, ndone;
    nbusy = 0; ndone = 0;
    c0 = bif.inj_count_o;
    idle_inputs();
    bif.arm_i = 1; bif.target_i = 3; bif.mode_i = 1;
    bif.mask_i = '1; bif.delay_i = 0; bif.len_i = 5;
    tick();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bif.busy_o === 1'b1) nbusy++;
      if (bif.done_o === 1'b1 && i == 5) ndone++;
      g = d_vec(); e = m_vec();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL dry cyc%0d got %h exp %h", i, g, e);
      end
      tick();
    end
    n_cmp++;
    if (nbusy != 5 || ndone != 1 || bif.inj_count_o !== c0) begin
      n_bad++;
      $display("FAIL dry timing got busy%0d done%0d cnt%0d exp 5/1/%0d",
               nbusy, ndone, bif.inj_count_o, c0);
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] g, e;
    for (int i = 0; i < 600; i++) begin
      bif.arm_i    = ($urandom_range(0, 3) == 0);
      bif.abort_i  = ($urandom_range(0, 19) == 0);
      bif.target_i = 2'($urandom_range(0, 3));
      bif.mode_i   = 2'($urandom_range(0, 3));
      bif.mask_i   = $urandom;
      bif.delay_i  = CW'($urandom_range(0, 4));
      bif.len_i    = CW'($urandom_range(0, 6));
      bif.trig_i   = ($urandom_range(0, 3) != 0);
      bif.res0_i   = $urandom;
      bif.res1_i   = $urandom;
      bif.res2_i   = $urandom;
      #1;
      g = d_vec(); e = m_vec();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL random cyc%0d got %h exp %h", i, g, e);
      end
      tick();
    end
    idle_inputs();
    bif.abort_i = 1;
    tick();
    idle_inputs();
  endtask

  task automatic test_saturation();
    sif.arm_i = 0; sif.target_i = 0; sif.mode_i = 1;
    sif.mask_i = 32'h0000_0001; sif.delay_i = 0; sif.len_i = 8;
    sif.res0_i = 32'h1234_5678;
    for (int b = 0; b < 3; b++) begin
      @(posedge clk); #1;
      sif.arm_i = 1;
      @(posedge clk); #1;
      sif.arm_i = 0;
      repeat (10) @(posedge clk);
      #1;
      if (b == 0) begin
        n_cmp++;
        if (sif.inj_count_o !== 4'd8) begin
          n_bad++;
          $display("FAIL sat burst1 got %0d exp 8", sif.inj_count_o);
        end
      end
    end
    n_cmp++;
    if (sif.inj_count_o !== 4'hF) begin
      n_bad++;
      $display("FAIL sat count got %h exp f", sif.inj_count_o);
    end
    sif.arm_i = 1;
    @(posedge clk); #1;
    sif.arm_i = 0;
    @(posedge clk); #2;
    n_cmp++;
    if (sif.res0_o !== 32'h1234_5679) begin
      n_bad++;
      $display("FAIL sat midburst got %h exp 12345679", sif.res0_o);
    end
    rst_n_s = 0;
    #1;
    n_cmp++;
    if (sif.res0_o !== 32'h1234_5678 || sif.inj_count_o !== 4'd0 ||
        sif.busy_o !== 1'b0 || sif.inject_o !== 1'b0) begin
      n_bad++;
      $display("FAIL sat reset got %h/%0d/%b/%b exp 12345678/0/0/0",
               sif.res0_o, sif.inj_count_o, sif.busy_o, sif.inject_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (sif.done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL sat reset done got %b exp 0", sif.done_o);
    end
    rst_n_s = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stuck_trig();
    test_abort();
    test_dry_run();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
